ifetch_responder: RTL and testbench

- Responder side of the fetch-address interface. Takes the fetch PC and the redirect (br_en/br_addr), and runs one bus request at a time to instruction memory over a req/ack handshake.
- Buffers returned instructions in a 2-entry FIFO toward decode.
- Drives `stall` back to the PC generator.
- Sits between the fetch PC stage and decode.

---
 rtl/ifetch_pkg.sv | 36 +++
 rtl/ifetch_fifo2.sv | 74 +++++++
 rtl/ifetch_responder.sv | 194 +++++++++++++++++++
 tb/tb_ifetch_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch responder and its output FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ifetch_pkg;

  // Bus-side control state: idle, one request outstanding, or dead after a bus timeout
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  // Instruction handed to decode when the bus never answers (addi x0,x0,0)
  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  // One FIFO slot toward decode
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Build an entry from its fields
  function automatic fetch_entry_t make_entry(input logic [31:0] instr,
                                              input logic [31:0] pc,
                                              input logic        err);
    fetch_entry_t e;
    e.instr = instr;
    e.pc    = pc;
    e.err   = err;
    return e;
  endfunction

endpackage

// File: rtl/ifetch_fifo2.sv
// Two-entry fetch FIFO toward decode with synchronous flush; slot 0 is always the head.
// Latency: one cycle from push to head visible on o_head/o_vld.
// Backpressure: a push into a full FIFO without a same-cycle pop is dropped; the caller's credit rule prevents it.
module ifetch_fifo2
  import ifetch_pkg::*;
(
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_push_dat,
  input  logic               i_pop,
  output logic               o_vld,
  output logic [ENTRY_W-1:0] o_head,
  output logic [1:0]         o_count
);

  fetch_entry_t r_slot0;
  fetch_entry_t r_slot1;
  logic [1:0]   r_count;

  fetch_entry_t w_din;
  logic         w_do_pop;
  logic         w_do_push;

  assign w_din     = fetch_entry_t'(i_push_dat);
  assign w_do_pop  = i_pop & (r_count != 2'd0);
  assign w_do_push = i_push & ((r_count != 2'd2) | w_do_pop);

  // Shift-style storage: a pop moves slot 1 forward so the head never needs a read pointer
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      // A flush drops everything; an entry pushed in the same cycle still lands
      r_count <= {1'b0, i_push};
      if (i_push) begin
        r_slot0 <= w_din;
      end
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_slot0 <= w_din;
          end else begin
            r_slot1 <= w_din;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_slot0 <= r_slot1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_slot0 <= w_din;
          end else begin
            r_slot0 <= r_slot1;
            r_slot1 <= w_din;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_vld   = (r_count != 2'd0);
  assign o_head  = r_slot0;
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_responder.sv
// Fetch responder: issues one instruction-memory request at a time and queues returns for decode.
// Latency: PC to dec_valid is 2 cycles with zero-wait memory; sustained 1 instruction per cycle.
// Backpressure: stall (combinational) holds the PC generator whenever a new request cannot be issued.
module ifetch_responder
  import ifetch_pkg::*;
#(
  parameter int          DEPTH       = 2,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_C
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] PC,
  input  logic        br_en,
  input  logic [31:0] br_addr,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_err,
  input  logic        dec_ready
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       OCC_MAX = 3'(DEPTH - 1);

  // Registered state
  state_t           r_state;
  logic             r_mem_req;
  logic [31:0]      r_mem_addr;
  logic             r_flush_pend;
  logic             r_redir_pend;
  logic [31:0]      r_redir_addr;
  logic [CNT_W-1:0] r_wait_cnt;

  // Next-state values
  state_t           w_state_nxt;
  logic             w_mem_req_nxt;
  logic [31:0]      w_mem_addr_nxt;
  logic             w_flush_pend_nxt;
  logic             w_redir_pend_nxt;
  logic [31:0]      w_redir_addr_nxt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;

  // Datapath / control wires
  logic             w_in_wait;
  logic             w_ack;
  logic             w_timeout;
  logic             w_flush;
  logic             w_pop;
  logic             w_push_data;
  logic             w_push;
  logic [1:0]       w_count;
  logic [2:0]       w_occ_next;
  logic             w_slot_open;
  logic             w_accept;
  logic [31:0]      w_issue_addr;
  logic             w_fifo_vld;
  fetch_entry_t     w_push_ent;
  logic [ENTRY_W-1:0] w_head_vec;
  fetch_entry_t     w_head;

  assign w_in_wait = (r_state == S_WAIT);
  assign w_ack     = w_in_wait & mem_ack;
  assign w_timeout = w_in_wait & ~mem_ack & (r_wait_cnt == TO_LAST);

  // Redirects flush the decode queue in every live state; after a bus error they are ignored
  assign w_flush = br_en & (r_state != S_ERR);

  // Same-cycle flush beats a decode pop, and returning data is dropped under a redirect
  assign w_pop       = dec_valid & dec_ready & ~br_en;
  assign w_push_data = w_ack & ~r_flush_pend & ~br_en;
  assign w_push      = w_push_data | w_timeout;

  assign w_push_ent = w_timeout ? make_entry(NOP_INSTR, r_mem_addr, 1'b1)
                                : make_entry(mem_rdata, r_mem_addr, 1'b0);

  // Occupancy after this edge; a request may only go out if its return will find a free slot
  assign w_occ_next = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, w_push};

  // The bus is free for a new request when idle or when the outstanding one completes now
  assign w_slot_open = (r_state == S_IDLE) | w_ack;
  assign w_accept    = w_slot_open & (br_en | (w_occ_next <= OCC_MAX));
  assign stall       = ~w_accept;

  // A fresh redirect wins, then a remembered one, else the sequential PC
  assign w_issue_addr = br_en        ? br_addr :
                        r_redir_pend ? r_redir_addr : PC;

  ifetch_fifo2 u_fifo (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .i_flush    (w_flush),
    .i_push     (w_push),
    .i_push_dat (w_push_ent),
    .i_pop      (w_pop),
    .o_vld      (w_fifo_vld),
    .o_head     (w_head_vec),
    .o_count    (w_count)
  );

  assign w_head    = fetch_entry_t'(w_head_vec);
  assign dec_valid = w_fifo_vld;
  assign dec_instr = w_head.instr;
  assign dec_pc    = w_head.pc;
  assign dec_err   = w_head.err;

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

  // Next-state and bus-control decode; every field holds unless a rule below changes it
  always_comb begin
    w_state_nxt      = r_state;
    w_mem_req_nxt    = r_mem_req;
    w_mem_addr_nxt   = r_mem_addr;
    w_flush_pend_nxt = r_flush_pend;
    w_redir_pend_nxt = r_redir_pend;
    w_redir_addr_nxt = r_redir_addr;
    w_wait_cnt_nxt   = r_wait_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt      = S_WAIT;
          w_mem_req_nxt    = 1'b1;
          w_mem_addr_nxt   = w_issue_addr;
          w_redir_pend_nxt = 1'b0;
          w_wait_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (w_ack) begin
          // Whatever came back, the discard obligation is now met
          w_flush_pend_nxt = 1'b0;
          if (w_accept) begin
            w_mem_req_nxt    = 1'b1;
            w_mem_addr_nxt   = w_issue_addr;
            w_redir_pend_nxt = 1'b0;
            w_wait_cnt_nxt   = '0;
          end else begin
            w_state_nxt   = S_IDLE;
            w_mem_req_nxt = 1'b0;
          end
        end else if (w_timeout) begin
          w_state_nxt    = S_ERR;
          w_mem_req_nxt  = 1'b0;
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          // The in-flight request cannot be cancelled: mark its data for discard and remember the target
          if (br_en) begin
            w_flush_pend_nxt = 1'b1;
            w_redir_pend_nxt = 1'b1;
            w_redir_addr_nxt = br_addr;
          end
        end
      end
      S_ERR: begin
        w_mem_req_nxt = 1'b0;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // State and bus-control registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_flush_pend <= 1'b0;
      r_redir_pend <= 1'b0;
      r_redir_addr <= 32'h0;
      r_wait_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_redir_pend <= w_redir_pend_nxt;
      r_redir_addr <= w_redir_addr_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch_responder.sv
// Bench for ifetch_responder: directed scenarios plus a randomized run against a queue-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ifetch_responder;

  localparam int TIMEOUT = 255;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] PC;
  logic        br_en;
  logic [31:0] br_addr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_err;
  logic        dec_ready;

  ifetch_responder #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .PC        (PC),
    .br_en     (br_en),
    .br_addr   (br_addr),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dec_valid (dec_valid),
    .dec_instr (dec_instr),
    .dec_pc    (dec_pc),
    .dec_err   (dec_err),
    .dec_ready (dec_ready)
  );

  always #5 CLK = ~CLK;

  // Reference model: what decode should see, and what the bus is doing
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } ent_t;

  ent_t        q[$];
  bit          m_busy;
  bit          m_drop;
  bit          m_redir_vld;
  bit          m_err;
  logic [31:0] m_addr;
  logic [31:0] m_redir;
  logic [31:0] m_pc;
  int          m_wait;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy      = 1'b0;
    m_drop      = 1'b0;
    m_redir_vld = 1'b0;
    m_err       = 1'b0;
    m_addr      = 32'h0;
    m_redir     = 32'h0;
    m_wait      = 0;
  endtask

  task automatic apply_reset(input logic [31:0] start_pc);
    RSTn = 1'b0; br_en = 1'b0; br_addr = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0; dec_ready = 1'b0;
    model_reset();
    m_pc = start_pc;
    PC   = start_pc;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model at the edge
  task automatic step(input bit be, input logic [31:0] ba, input bit ack_in, input bit rdy);
    bit ack, pop, push, tmo, can_issue, acc, seq_used;
    int occ;
    ent_t e;
    br_en = be; br_addr = ba; mem_ack = ack_in; dec_ready = rdy;
    mem_rdata = $urandom;
    PC = m_pc;
    #1;
    ack  = m_busy && ack_in;
    pop  = (q.size() > 0) && rdy && !be;
    push = ack && !m_drop && !be;
    tmo  = m_busy && !ack_in && (m_wait == TIMEOUT - 1);
    occ  = q.size() - (pop ? 1 : 0) + (push ? 1 : 0);
    can_issue = !m_err && (!m_busy || ack);
    acc  = can_issue && (be || occ <= 1);

    check("stall", stall, !acc);
    check("mem_req", mem_req, m_busy);
    if (m_busy) check("mem_addr", mem_addr, m_addr);
    check("dec_valid", dec_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("dec_pc", dec_pc, q[0].pc);
      check("dec_instr", dec_instr, q[0].instr);
      check("dec_err", dec_err, q[0].err);
    end

    @(posedge CLK);
    if (be && !m_err) q.delete();
    else if (pop) q.pop_front();
    if (push) begin
      e.instr = mem_rdata; e.pc = m_addr; e.err = 1'b0;
      q.push_back(e);
    end
    seq_used = acc && !be && !m_redir_vld;
    if (acc) begin
      m_addr      = be ? ba : (m_redir_vld ? m_redir : m_pc);
      m_busy      = 1'b1;
      m_wait      = 0;
      m_drop      = 1'b0;
      m_redir_vld = 1'b0;
    end else if (ack) begin
      m_busy = 1'b0;
      m_drop = 1'b0;
    end else if (tmo) begin
      e.instr = NOP; e.pc = m_addr; e.err = 1'b1;
      q.push_back(e);
      m_busy = 1'b0;
      m_err  = 1'b1;
    end else if (m_busy) begin
      m_wait++;
      if (be) begin
        m_drop      = 1'b1;
        m_redir_vld = 1'b1;
        m_redir     = ba;
      end
    end
    if (be) m_pc = ba + 32'd4;
    else if (seq_used) m_pc = m_pc + 32'd4;
    @(negedge CLK);
  endtask

  initial begin
    bit          be, ak, rd;
    logic [31:0] ba;

    // Reset values
    apply_reset(32'h0);
    RSTn = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_dec_valid", dec_valid, 1'b0);
    check("rst_dec_instr", dec_instr, 32'h0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_err", dec_err, 1'b0);
    @(negedge CLK);
    RSTn = 1'b1;

    // Zero-wait streaming from PC 0
    repeat (8) step(1'b0, 32'h0, m_busy, 1'b1);

    // Decode stalls: FIFO fills, then drains in order
    repeat (6) step(1'b0, 32'h0, m_busy, 1'b0);
    repeat (8) step(1'b0, 32'h0, m_busy, 1'b1);

    // Slow ack with a redirect during the wait
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h100, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    repeat (5) step(1'b0, 32'h0, m_busy, 1'b1);

    // Redirect in the same cycle as an ack
    step(1'b1, 32'h200, m_busy, 1'b1);
    repeat (5) step(1'b0, 32'h0, m_busy, 1'b1);
    step(1'b1, 32'h300, m_busy, 1'b0);
    repeat (4) step(1'b0, 32'h0, m_busy, 1'b1);

    // Bus timeout
    for (int i = 0; i < 10 && !m_busy; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    check("busy_before_timeout", mem_req, 1'b1);
    repeat (TIMEOUT + 6) step(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h500, 1'b1, 1'b1);

    // Reset in the middle of a request; a late ack must be ignored
    apply_reset(32'h1000);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
    RSTn = 1'b0; br_en = 1'b0; mem_ack = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_dec_valid", dec_valid, 1'b0);
    check("midrst_stall", stall, 1'b0);
    model_reset();
    m_pc = 32'h4000;
    mem_ack = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 32'h0, m_busy, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      be = ($urandom_range(0, 19) == 0);
      ba = $urandom;
      ba = ba & 32'hFFFF_FFFC;
      ak = ($urandom_range(0, 9) < 6);
      rd = ($urandom_range(0, 3) != 0);
      step(be, ba, ak, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
